bus_cycle_arbiter: RTL and testbench
====================================

// Module: bus_cycle_arbiter
// PURPOSE
//  Shares one 8088-style peripheral bus (memory/IO FSM slaves) among NUM_REQ requesters.
//  Round-robin arbitration, then one T1-T4 bus cycle per grant: ALE, RD_n/WR_n, IOM, chip selects, data.
//  Sits between CPU/DMA request ports and the memory/IO peripheral FSMs.
// PARAMETERS
//  NUM_REQ   2   number of requesters (2..4)
//  ADDR_W    20  address width
//  DATA_W    8   data width
//  MAX_WAIT  7   max wait states before forced completion (WAIT_STATE_EN only)
// PORTS
//  CLK        in   1               clock, all state on posedge
//  RESET      in   1               asynchronous, active-high reset
//  req        in   NUM_REQ         request per requester, held until its done
//  req_we     in   NUM_REQ         1=write, 0=read
//  req_iom    in   NUM_REQ         1=IO cycle, 0=memory cycle
//  req_addr   in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  gnt        out  NUM_REQ         one-hot grant, T1..T4 of owned cycle
//  done       out  NUM_REQ         one-cycle completion pulse in T4
//  rdata      out  DATA_W          read data, valid with done, held until next read
//  err        out  1               wait timeout pulse with done (0 without WAIT_STATE_EN)
//  ALE        out  1               address latch enable, high in T1 only
//  RD_n       out  1               read strobe, low in T2..T3(+TW)
//  WR_n       out  1               write strobe, low in T2..T3(+TW)
//  IOM        out  1               latched req_iom, T1..T4
//  MEM_CS     out  1               ~IOM, T1..T4
//  IO_CS      out  1               IOM, T1..T4
//  A          out  ADDR_W          latched address, T1..T4
//  D_out      out  DATA_W          latched write data
//  D_oe       out  1               drive D_out onto data bus: write cycles T1..T4
//  D_in       in   DATA_W          bus data from peripheral
//  READY      in   1               peripheral ready (WAIT_STATE_EN only)
// BEHAVIOUR
//  - Reset (async): state IDLE; gnt,done,err,ALE,D_oe,MEM_CS,IO_CS,IOM=0; RD_n,WR_n=1; A,D_out,rdata=0;
//    rr pointer=0. Reset mid-cycle aborts immediately; no done issued.
//  - FSM: IDLE->T1->T2->T3->[TW..]->T4->IDLE. One IDLE cycle always separates cycles (slave END->IDLE).
//  - IDLE: if any req, pick first set req at/after rr pointer (wrap NUM_REQ-1 -> 0); latch addr,
//    wdata, we, iom of winner; gnt winner; ->T1. Else stay IDLE, outputs inactive.
//  - T1: ALE=1, A/IOM/CS valid. T2: ALE=0, RD_n or WR_n low. T3: strobe low; read samples D_in into
//    rdata at T3 exit edge. T4: strobes high, done[winner]=1, rr pointer=winner+1 mod NUM_REQ.
//  - Latency req->done: 5 cycles from IDLE (req seen in IDLE, done in T4), no waits.
//  - Requests sampled only in IDLE; req dropping after grant does not abort the cycle.
//    req still high at done restarts only if rr selects it again (fairness: others first).
//  - Simultaneous reqs: rr order; single requester may be regranted back-to-back every 5 cycles.
//  - Only one of RD_n/WR_n ever low; D_oe never high on read cycles.
// CONFIGURATION
//  WAIT_STATE_EN defined: in T3, READY=0 -> TW; TW repeats while READY=0; READY=1 ->T4
//    (read samples D_in on the READY=1 exit edge). Wait counter reaching MAX_WAIT forces T4 with
//    err=1 alongside done; rdata then holds D_in at forced exit.
//  WAIT_STATE_EN undefined: READY ignored, no TW state, err tied 0, fixed 5-cycle cycle.
// TESTING
//  - Reset mid-T2 read (RD_n=0) -> RD_n=1, gnt=0, no done, FSM IDLE; next req completes normally.
//  - req[0] read 20'h00010, slave returns 8'hA5 in T3 -> ALE T1, RD_n low T2-T3, done[0] cycle 5, rdata=8'hA5.
//  - req[1] IO write addr 20'h00080 data 8'h3C -> IO_CS=1, MEM_CS=0, WR_n low T2-T3, D_oe T1-T4, D_out=8'h3C.
//  - req=2'b11 held continuously -> grants alternate 0,1,0,1; each done 5 cycles apart, never overlapping.
//  - WAIT_STATE_EN, READY low 2 cycles in read -> two TW, done at cycle 7, err=0, rdata sampled on READY.
//  - WAIT_STATE_EN, READY stuck low -> MAX_WAIT=7 TW then T4, done and err pulse together.

Source files
------------

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin owner selection for NUM_REQ requesters,
// then one 8088-style T1..T4 bus cycle per grant (ALE, RD_n/WR_n, IOM, CS, data).
// Optional feature macro: WAIT_STATE_EN -- enables READY-driven TW wait states
// with a MAX_WAIT timeout that forces completion and flags err. MAX_WAIT >= 1.
// Without the macro READY is ignored and every cycle is exactly IDLE+T1..T4.
module bus_cycle_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 7
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_iom,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      ALE,
  output logic                      RD_n,
  output logic                      WR_n,
  output logic                      IOM,
  output logic                      MEM_CS,
  output logic                      IO_CS,
  output logic [ADDR_W-1:0]         A,
  output logic [DATA_W-1:0]         D_out,
  output logic                      D_oe,
  input  logic [DATA_W-1:0]         D_in,
  input  logic                      READY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef WAIT_STATE_EN
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              force_err;
  logic              err_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;
  // READY and MAX_WAIT only matter when wait states are built in
  logic unused_cfg;
  assign unused_cfg = READY ^ (MAX_WAIT < 1);
`endif

  state_t state_q, state_d;

  logic [IDX_W-1:0] rr_q, owner_q, pick;
  logic             pick_vld;
  logic             load, sample, rr_adv;
  logic             busy, strobe;
  logic             we_q, iom_q;
  logic [NUM_REQ-1:0] rot;
  int               sum;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;

  // Per-requester views of the packed request buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_v[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_v[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Rotate requests so bit 0 is the requester at the round-robin pointer
  assign rot = NUM_REQ'({req, req} >> rr_q);

  // First set request at/after the pointer, mapped back to a requester index
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    sum      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && rot[k]) begin
        pick_vld = 1'b1;
        sum      = int'(rr_q) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        pick     = IDX_W'(sum);
      end
    end
  end

  // Bus-cycle sequencer: next state, datapath strobes and Moore bus outputs
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = 1'b0;
    rr_adv  = 1'b0;
`ifdef WAIT_STATE_EN
    wcnt_d    = wcnt_q;
    force_err = 1'b0;
`endif
    busy   = (state_q != S_IDLE);
    strobe = (state_q == S_T2) || (state_q == S_T3);
`ifdef WAIT_STATE_EN
    if (state_q == S_TW) strobe = 1'b1;
`endif
    gnt    = busy ? (NUM_REQ'(1) << owner_q) : '0;
    done   = '0;
    ALE    = (state_q == S_T1);
    RD_n   = ~(strobe & ~we_q);
    WR_n   = ~(strobe & we_q);
    IOM    = busy & iom_q;
    IO_CS  = busy & iom_q;
    MEM_CS = busy & ~iom_q;
    D_oe   = busy & we_q;
    err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          load    = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
`ifdef WAIT_STATE_EN
      S_T3: begin
        if (READY) begin
          sample  = 1'b1;
          state_d = S_T4;
        end else begin
          wcnt_d  = WCNT_W'(1);
          state_d = S_TW;
        end
      end
      S_TW: begin
        if (READY) begin
          sample  = 1'b1;
          state_d = S_T4;
        end else if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
          // slave never answered: finish anyway and report it
          sample    = 1'b1;
          force_err = 1'b1;
          state_d   = S_T4;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
`else
      S_T3: begin
        sample  = 1'b1;
        state_d = S_T4;
      end
`endif
      S_T4: begin
        done    = NUM_REQ'(1) << owner_q;
`ifdef WAIT_STATE_EN
        err     = err_q;
`endif
        rr_adv  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any cycle in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef WAIT_STATE_EN
  // Wait-state counter, counts TW cycles of the current bus cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`endif

  // Latched cycle attributes, read data capture and round-robin pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      iom_q   <= 1'b0;
      A       <= '0;
      D_out   <= '0;
      rdata   <= '0;
`ifdef WAIT_STATE_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (load) begin
        owner_q <= pick;
        we_q    <= req_we[pick];
        iom_q   <= req_iom[pick];
        A       <= addr_v[pick];
        D_out   <= wdata_v[pick];
      end
      // write cycles leave rdata holding the last read
      if (sample && !we_q) rdata <= D_in;
      if (rr_adv) begin
        if (int'(owner_q) == NUM_REQ - 1) rr_q <= '0;
        else                              rr_q <= owner_q + IDX_W'(1);
      end
`ifdef WAIT_STATE_EN
      if (load)      err_q <= 1'b0;
      if (force_err) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Bench for bus_cycle_arbiter: a cycle-position model of the bus protocol is
// checked against the DUT every cycle, plus directed transfers with literal
// expectations for timing, strobes, data and round-robin order.
module tb_bus_cycle_arbiter;
  localparam int NR  = 2;
  localparam int AW  = 20;
  localparam int DW  = 8;
  localparam int MW  = 7;
  localparam int AWT = NR * AW;
  localparam int DWT = NR * DW;

  logic           CLK;
  logic           RESET;
  logic [NR-1:0]  req, req_we, req_iom;
  logic [AWT-1:0] req_addr;
  logic [DWT-1:0] req_wdata;
  logic [NR-1:0]  gnt, done;
  logic [DW-1:0]  rdata;
  logic           err, ALE, RD_n, WR_n, IOM, MEM_CS, IO_CS, D_oe;
  logic [AW-1:0]  A;
  logic [DW-1:0]  D_out;
  logic [DW-1:0]  D_in;
  logic           READY;

  bus_cycle_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_we(req_we), .req_iom(req_iom),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM),
    .MEM_CS(MEM_CS), .IO_CS(IO_CS), .A(A), .D_out(D_out), .D_oe(D_oe),
    .D_in(D_in), .READY(READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- protocol model ----------------
  // m_pos: 0 idle, 1 T1, 2 T2, 3 strobe phase (T3 and any waits), 4 T4
  int             m_pos, m_wait, m_own, m_rr, m_pick;
  logic           m_we, m_iom, m_err, e_busy, e_strb;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wd, m_rdata;

  initial begin : model_cmp
    m_pos = 0; m_wait = 0; m_own = 0; m_rr = 0; m_pick = 0;
    m_we = 1'b0; m_iom = 1'b0; m_err = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        m_pos = 0; m_wait = 0; m_rr = 0; m_own = 0; m_err = 1'b0; m_rdata = '0;
      end
      e_busy = (m_pos != 0);
      e_strb = (m_pos == 2) || (m_pos == 3);
      chk("gnt",    32'(gnt),    e_busy ? (32'd1 << m_own) : 32'd0);
      chk("done",   32'(done),   (m_pos == 4) ? (32'd1 << m_own) : 32'd0);
      chk("ALE",    32'(ALE),    32'(m_pos == 1));
      chk("RD_n",   32'(RD_n),   32'(!(e_strb && !m_we)));
      chk("WR_n",   32'(WR_n),   32'(!(e_strb && m_we)));
      chk("IOM",    32'(IOM),    32'(e_busy && m_iom));
      chk("IO_CS",  32'(IO_CS),  32'(e_busy && m_iom));
      chk("MEM_CS", 32'(MEM_CS), 32'(e_busy && !m_iom));
      chk("D_oe",   32'(D_oe),   32'(e_busy && m_we));
      chk("err",    32'(err),    32'((m_pos == 4) && m_err));
      chk("rdata",  32'(rdata),  32'(m_rdata));
      if (RESET) begin
        chk("rst_A",     32'(A),     32'd0);
        chk("rst_D_out", 32'(D_out), 32'd0);
      end else begin
        if (e_busy) chk("A", 32'(A), 32'(m_addr));
        if (e_busy && m_we) chk("D_out", 32'(D_out), 32'(m_wd));
        case (m_pos)
          0: begin
            if (req != '0) begin
              m_pick = -1;
              for (int k = 0; k < NR; k++)
                if (m_pick < 0 && ((int'(req) >> ((m_rr + k) % NR)) & 1) == 1)
                  m_pick = (m_rr + k) % NR;
              m_own  = m_pick;
              m_we   = ((int'(req_we) >> m_pick) & 1) == 1;
              m_iom  = ((int'(req_iom) >> m_pick) & 1) == 1;
              m_addr = AW'(req_addr >> (m_pick * AW));
              m_wd   = DW'(req_wdata >> (m_pick * DW));
              m_err  = 1'b0;
              m_wait = 0;
              m_pos  = 1;
            end
          end
          1: m_pos = 2;
          2: m_pos = 3;
          3: begin
`ifdef WAIT_STATE_EN
            if (READY) begin
              if (!m_we) m_rdata = D_in;
              m_pos = 4;
            end else if (m_wait == MW) begin
              if (!m_we) m_rdata = D_in;
              m_err = 1'b1;
              m_pos = 4;
            end else begin
              m_wait++;
            end
`else
            if (!m_we) m_rdata = D_in;
            m_pos = 4;
`endif
          end
          4: begin
            m_rr  = (m_own + 1) % NR;
            m_pos = 0;
          end
          default: m_pos = 0;
        endcase
      end
    end
  end

  // ---------------- directed transfers ----------------
  typedef struct {
    int           dcyc;
    logic [NR-1:0] who;
    logic [31:0]  ale, rd, wr, doe, mem, io, errb;
  } obs_t;

  // Issue one request in an IDLE cycle (cycle 1) and record per-cycle outputs
  // as bit masks indexed by cycle number until done (bounded).
  task automatic xfer(input int idx, input logic we, input logic iom,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [31:0] rdy_low, input logic [DW-1:0] din,
                      output obs_t o);
    logic low;
    o.dcyc = 0; o.who = '0; o.ale = '0; o.rd = '0; o.wr = '0;
    o.doe = '0; o.mem = '0; o.io = '0; o.errb = '0;
    req       = NR'(1 << idx);
    req_we    = we  ? req : '0;
    req_iom   = iom ? req : '0;
    req_addr  = AWT'(addr) << (idx * AW);
    req_wdata = DWT'(wd) << (idx * DW);
    for (int c = 1; c <= 40; c++) begin
      low   = ((rdy_low >> c) & 32'd1) != 0;
      READY = !low;
      D_in  = low ? DW'(c) : din;
      o.ale  |= 32'(ALE)    << c;
      o.rd   |= 32'(!RD_n)  << c;
      o.wr   |= 32'(!WR_n)  << c;
      o.doe  |= 32'(D_oe)   << c;
      o.mem  |= 32'(MEM_CS) << c;
      o.io   |= 32'(IO_CS)  << c;
      o.errb |= 32'(err)    << c;
      if (done != '0) begin
        o.dcyc = c;
        o.who  = done;
        req    = '0;
        step();
        break;
      end
      step();
    end
    req   = '0;
    READY = 1'b1;
  endtask

  obs_t o;
  int   log_cyc [8];
  logic [NR-1:0] log_who [8];
  int   n_log;

  initial begin : stim
    RESET = 1'b1; READY = 1'b1; D_in = '0;
    req = '0; req_we = '0; req_iom = '0; req_addr = '0; req_wdata = '0;
    n_log = 0;
    step(); step();
    chk("rst_gnt",  32'(gnt),   32'd0);
    chk("rst_RD_n", 32'(RD_n),  32'd1);
    chk("rst_WR_n", 32'(WR_n),  32'd1);
    chk("rst_ALE",  32'(ALE),   32'd0);
    chk("rst_rdata",32'(rdata), 32'd0);
    RESET = 1'b0;
    step();

    // reset in the middle of a read's T2
    req = 2'b01; req_we = '0; req_iom = '0; req_addr = AWT'(20'h00123);
    step();
    chk("abort_T1_ALE", 32'(ALE), 32'd1);
    step();
    chk("abort_T2_RD_n", 32'(RD_n), 32'd0);
    RESET = 1'b1; req = '0;
    #1;
    chk("abort_RD_n", 32'(RD_n), 32'd1);
    chk("abort_gnt",  32'(gnt),  32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    RESET = 1'b0;
    step();

    // memory read by requester 0, slave returns A5
    xfer(0, 1'b0, 1'b0, 20'h00010, 8'h00, 32'h0, 8'hA5, o);
    chk("rd_done_cyc", 32'(o.dcyc), 32'd5);
    chk("rd_done_who", 32'(o.who),  32'h1);
    chk("rd_ALE",      o.ale,       32'h04);
    chk("rd_RD_low",   o.rd,        32'h18);
    chk("rd_WR_low",   o.wr,        32'h0);
    chk("rd_D_oe",     o.doe,       32'h0);
    chk("rd_MEM_CS",   o.mem,       32'h3C);
    chk("rd_rdata",    32'(rdata),  32'hA5);

    // IO write by requester 1
    xfer(1, 1'b1, 1'b1, 20'h00080, 8'h3C, 32'h0, 8'h00, o);
    chk("wr_done_cyc", 32'(o.dcyc), 32'd5);
    chk("wr_done_who", 32'(o.who),  32'h2);
    chk("wr_WR_low",   o.wr,        32'h18);
    chk("wr_RD_low",   o.rd,        32'h0);
    chk("wr_D_oe",     o.doe,       32'h3C);
    chk("wr_IO_CS",    o.io,        32'h3C);
    chk("wr_MEM_CS",   o.mem,       32'h0);
    chk("wr_rdata_held", 32'(rdata), 32'hA5);

    // both requesting continuously: alternate 0,1,0,1, done every 5 cycles
    req = 2'b11; req_we = '0; req_iom = '0;
    req_addr = {20'h20000, 20'h10000}; req_wdata = '0; D_in = 8'h77;
    for (int c = 1; c <= 20; c++) begin
      if (done != '0 && n_log < 8) begin
        log_cyc[n_log] = c;
        log_who[n_log] = done;
        n_log++;
      end
      if (c == 20) req = '0;
      step();
    end
    chk("rr_count", 32'(n_log), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_done_cyc", 32'(log_cyc[i]), 32'(5 * (i + 1)));
      chk("rr_done_who", 32'(log_who[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

`ifdef WAIT_STATE_EN
    // READY low in T3 and first TW: two waits, data taken when READY returns
    xfer(0, 1'b0, 1'b0, 20'h00200, 8'h00, 32'h30, 8'h5A, o);
    chk("ws_done_cyc", 32'(o.dcyc), 32'd7);
    chk("ws_RD_low",   o.rd,        32'h78);
    chk("ws_err",      o.errb,      32'h0);
    chk("ws_rdata",    32'(rdata),  32'h5A);

    // READY stuck low: MAX_WAIT waits then forced T4 with err
    xfer(1, 1'b0, 1'b1, 20'h00300, 8'h00, 32'hFFFF_FFFE, 8'hEE, o);
    chk("to_done_cyc", 32'(o.dcyc), 32'd12);
    chk("to_err",      o.errb,      32'h1000);
    chk("to_RD_low",   o.rd,        32'h0FF8);
    chk("to_rdata",    32'(rdata),  32'h0B);
`else
    // READY ignored without wait states
    xfer(0, 1'b0, 1'b0, 20'h00040, 8'h00, 32'hFFFF_FFFE, 8'hC3, o);
    chk("nw_done_cyc", 32'(o.dcyc), 32'd5);
    chk("nw_err",      o.errb,      32'h0);
    chk("nw_rdata",    32'(rdata),  32'h04);
`endif

    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
